// File: rtl/sp_ram_param.sv
// Single-port RAM with a registered read port, selectable read-during-write output behaviour,
// and a clear sweep that fills every word with INIT_VAL after reset or when clr is pulsed.
module sp_ram_param #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       DEPTH    = 2**ADDR_W,
  parameter int unsigned       RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              q_valid_q, q_valid_d;

  logic              in_range;
  logic [DATA_W-1:0] rd_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign in_range = ({1'b0, addr} < DEPTH_LIM);
  assign rd_data  = in_range ? mem[addr] : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data;
    case (state_q)
      CLEAR: begin
        // Port accesses and clr are ignored for the whole sweep.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = INIT_VAL;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (en && we) begin
          if (in_range) begin
            mem_we = 1'b1;
            if (RDW_MODE == 1) begin
              q_d       = data;
              q_valid_d = 1'b1;
            end else if (RDW_MODE == 2) begin
              q_d       = rd_data;
              q_valid_d = 1'b1;
            end
          end
        end else if (en) begin
          q_d       = rd_data;
          q_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  // Storage has no reset so it can map onto a RAM macro; rst only gates the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign busy    = (state_q == CLEAR);

endmodule

// File: tb/tb_sp_ram_param.sv
// Drives three differently-parameterised RAMs with shared stimulus and checks each
// against an array-based reference model every cycle.
module tb_sp_ram_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       en  = 1'b0;
  logic       we  = 1'b0;
  logic [5:0] addr = '0;
  logic [7:0] data = '0;

  logic [7:0] dq [3];
  logic       dv [3];
  logic       db [3];

  int n_cmp = 0;
  int n_err = 0;

  // Instance configuration: depth, read-during-write mode, clear value.
  int         c_dep [3] = '{64, 64, 48};
  int         c_rdw [3] = '{0, 1, 2};
  logic [7:0] c_ini [3] = '{8'h00, 8'hA5, 8'h00};

  logic [7:0] m_mem  [3][64];
  int         m_left [3];
  logic [7:0] m_q    [3];
  logic       m_qv   [3];

  always #5 clk = ~clk;

  sp_ram_param u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .we(we), .addr(addr), .data(data),
    .q(dq[0]), .q_valid(dv[0]), .busy(db[0])
  );
  sp_ram_param #(.RDW_MODE(1), .INIT_VAL(8'hA5)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .we(we), .addr(addr), .data(data),
    .q(dq[1]), .q_valid(dv[1]), .busy(db[1])
  );
  sp_ram_param #(.RDW_MODE(2), .DEPTH(48)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .we(we), .addr(addr), .data(data),
    .q(dq[2]), .q_valid(dv[2]), .busy(db[2])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: a sweep is simply "left" more words to fill before the port is usable.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_q[i] = 8'h00; m_qv[i] = 1'b0; m_left[i] = c_dep[i];
      end else if (m_left[i] > 0) begin
        m_mem[i][c_dep[i] - m_left[i]] = c_ini[i];
        m_left[i]--;
        m_qv[i] = 1'b0;
      end else if (clr) begin
        m_left[i] = c_dep[i];
        m_qv[i]   = 1'b0;
      end else if (en && we) begin
        m_qv[i] = 1'b0;
        if (int'(addr) < c_dep[i]) begin
          if (c_rdw[i] == 1) begin m_q[i] = data; m_qv[i] = 1'b1; end
          if (c_rdw[i] == 2) begin m_q[i] = m_mem[i][addr]; m_qv[i] = 1'b1; end
          m_mem[i][addr] = data;
        end
      end else if (en) begin
        m_q[i]  = (int'(addr) < c_dep[i]) ? m_mem[i][addr] : 8'h00;
        m_qv[i] = 1'b1;
      end else begin
        m_qv[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("q%0d", i),     64'(dq[i]), 64'(m_q[i]));
      chk($sformatf("qv%0d", i),    64'(dv[i]), 64'(m_qv[i]));
      chk($sformatf("busy%0d", i),  64'(db[i]), 64'(m_left[i] > 0));
    end
  endtask

  task automatic acc(input logic e, input logic w, input logic [5:0] a, input logic [7:0] d);
    en = e; we = w; addr = a; data = d;
    tick();
  endtask

  task automatic wait_idle(input string tag, input int exp_cycles);
    int n = 0;
    while (db[0] && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_left[i] = 0; m_q[i] = 8'h00; m_qv[i] = 1'b0;
      for (int j = 0; j < 64; j++) m_mem[i][j] = 8'h00;
    end

    // Reset for two cycles, then the power-on sweep.
    tick();
    chk("rst_busy", 64'(db[0]), 64'd1);
    chk("rst_q", 64'(dq[0]), 64'h0);
    tick();
    rst = 1'b0;
    wait_idle("init_sweep_len", 64);
    acc(1'b1, 1'b0, 6'd0, 8'h00);
    acc(1'b1, 1'b0, 6'd1, 8'h00);
    acc(1'b1, 1'b0, 6'd63, 8'h00);
    chk("rd63_q", 64'(dq[0]), 64'h00);
    acc(1'b0, 1'b0, 6'd0, 8'h00);

    // Write three words, read them back to back.
    acc(1'b1, 1'b1, 6'd0, 8'h01);
    acc(1'b1, 1'b1, 6'd1, 8'h02);
    acc(1'b1, 1'b1, 6'd2, 8'h03);
    for (int k = 0; k < 3; k++) begin
      acc(1'b1, 1'b0, 6'(k), 8'h00);
      chk("b2b_q", 64'(dq[0]), 64'(k + 1));
      chk("b2b_qv", 64'(dv[0]), 64'd1);
    end

    // Overwrite addr 1: observe each read-during-write flavour.
    acc(1'b1, 1'b1, 6'd1, 8'h04);
    chk("rdw0_q", 64'(dq[0]), 64'h03);
    chk("rdw0_qv", 64'(dv[0]), 64'd0);
    chk("rdw1_q", 64'(dq[1]), 64'h04);
    chk("rdw2_q", 64'(dq[2]), 64'h02);
    acc(1'b1, 1'b0, 6'd1, 8'h00);
    chk("rdw_rb0", 64'(dq[0]), 64'h04);
    chk("rdw_rb2", 64'(dq[2]), 64'h04);

    // Out-of-range write/read on the 48-deep instance.
    acc(1'b1, 1'b1, 6'd47, 8'h5C);
    acc(1'b1, 1'b1, 6'd50, 8'h77);
    acc(1'b1, 1'b0, 6'd50, 8'h00);
    chk("oor_q", 64'(dq[2]), 64'h00);
    chk("oor_qv", 64'(dv[2]), 64'd1);
    acc(1'b1, 1'b0, 6'd47, 8'h00);
    chk("d47_q", 64'(dq[2]), 64'h5C);

    // clr sweep with a second clr and port writes attempted mid-sweep.
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 9; k++) acc(1'b1, 1'b1, 6'(k), 8'h3C);
    clr = 1'b1;
    acc(1'b1, 1'b1, 6'd4, 8'h3C);
    clr = 1'b0;
    wait_idle("clr_sweep_rest", 54);
    for (int k = 0; k < 64; k++) acc(1'b1, 1'b0, 6'(k), 8'h00);
    chk("a5_last", 64'(dq[1]), 64'hA5);

    // Reset in the middle of a sweep restarts it.
    acc(1'b0, 1'b0, 6'd0, 8'h00);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b1;
    tick();
    tick();
    chk("midrst_q", 64'(dq[1]), 64'h00);
    rst = 1'b0;
    wait_idle("midrst_sweep_len", 64);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(299) == 0);
      clr  = ($urandom_range(79) == 0);
      en   = ($urandom_range(9) < 7);
      we   = $urandom_range(1);
      addr = 6'($urandom_range(63));
      data = 8'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
